conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Scheduler between the 5-row `line_buffer` and the convolution engine. It pulls one column per handshake from the line buffer and assembles a KxK sliding window in a shift register. It suppresses the K-1 warm-up columns at the start of every output row and presents each valid window with its (x, y) output coordinate. It sequences one IMG_W x IMG_H frame per `start` and reports completion.

## Interface
- `DATA_W`, 8, pixel width
- `K`, 5, kernel size; equals line-buffer row count
- `IMG_W`, 28, input columns per row
- `IMG_H`, 28, input rows per frame; output grid is (IMG_W-K+1) x (IMG_H-K+1) = 24x24
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: frame start pulse; ignored unless idle
- `col_data` in DATA_W*K: column from line buffer; row r (0 = top) at bits [r*DATA_W +: DATA_W]
- `valid_line_win` in 1: column valid from line buffer
- `ready_win` out 1: column accept to line buffer
- `win_data` out DATA_W*K*K: element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; c=0 oldest (leftmost) column
- `valid_win` out 1: window valid to conv engine
- `ready_out` in 1: conv engine accepts window
- `out_x`, `out_y` out 8 each: output coordinate of the presented window
- `busy` out 1: frame in progress
- `frame_done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1. This clears `col_cnt` (0..IMG_W-1) and `row_cnt` (0..IMG_H-K).
- Column handshake: `acc` = `valid_line_win` & `ready_win`.
- `ready_win` = (state==RUN) & (!`valid_win` | `ready_out`). The line buffer is never popped in IDLE/DONE or while a window is stalled.
- On `acc`, the shift register moves: column c takes column c+1, and `col_data` enters column K-1.
- `win_data` is the shift register directly. The `ready_win` gating guarantees it is stable whenever `valid_win`=1 and `ready_out`=0.
- On `acc` with `col_cnt` >= K-1:
  - set `valid_win`
  - `out_x` <= `col_cnt`-(K-1)
  - `out_y` <= `row_cnt`
- On `acc` with `col_cnt` < K-1 (warm-up): no window is emitted.
- `valid_win` clears on `ready_out` handshake unless a new emitting column is accepted in the same cycle. If so, it stays 1 and the coordinate updates.
- On `acc`, `col_cnt` increments. At IMG_W-1 it wraps to 0 and `row_cnt` increments.
- An `acc` on the last column of the last row (`col_cnt`=IMG_W-1, `row_cnt`=IMG_H-K) moves RUN -> DONE.
- In DONE, once no window is pending (`valid_win`=0, or the handshake completes this cycle):
  - `frame_done` = 1 for one cycle
  - state -> IDLE
- `busy` = (state != IDLE).
- Per frame: exactly IMG_W*(IMG_H-K+1) = 672 column handshakes and (IMG_W-K+1)*(IMG_H-K+1) = 576 windows.

## Timing
- Reset (async, any state): state IDLE; `ready_win`, `valid_win`, `busy`, `frame_done` = 0; `out_x`, `out_y`, `win_data`, counters = 0.
- `start` sampled at edge N: `busy` and `ready_win` (if `valid_line_win`) high from cycle N+1.
- Window latency: the emitting column is accepted at edge N; `valid_win` and the coordinate are visible in cycle N+1.
- Throughput: one window per cycle under continuous valid/ready. Each row start adds K-1 = 4 bubble cycles.
- Backpressure: while `valid_win`=1 and `ready_out`=0, `ready_win`=0 and `win_data`, `out_x`, `out_y` are held.
- `frame_done` asserts in the cycle after the last window handshake; `busy` drops together with `frame_done`.
- `start` during RUN/DONE or while `frame_done`=1: ignored.
- `rst_n` low mid-frame: immediate abort, no `frame_done`. A subsequent `start` restarts at (0,0) with warm-up.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN -> all outputs 0 asynchronously; after release `ready_win`=0 until `start`.
- Full frame, `valid_line_win`=1, `ready_out`=1:
  - 672 column handshakes, 576 windows, coordinates (0,0)..(23,0)..(23,23) in raster order
  - first `valid_win` one cycle after the 5th accepted column
  - `frame_done` one-cycle pulse after the last window
- Window content: drive `col_data` row r = 16*r + (column index mod 16) -> window (x,y) element (r,c) = 16*r + ((x+c) mod 16).
- Backpressure: hold `ready_out`=0 for 3 cycles at window (2,0) -> `valid_win`=1, `win_data` and `out_x`=2 stable, `ready_win`=0. On release, windows resume at (3,0) with no loss or duplication.
- Row wrap: after window (23,0) -> 4 accepted columns with `valid_win` low (when `ready_out`=1), then window (0,1).
- Stall source: `valid_line_win` toggling 1/0 -> same 576 windows in order; `start` pulsed mid-frame has no effect.

Source files
------------

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: handshake bundle around the window scheduler.
//   Line-buffer side : col_data, valid_line_win (to scheduler), ready_win (from it)
//   Conv-engine side : win_data, valid_win, out_x, out_y (from scheduler), ready_out (to it)
// modport slave  : the scheduler's view
// modport master : the surrounding environment's view (line buffer + conv engine)
interface conv_window_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int K      = 5
);
    logic [DATA_W*K-1:0]   col_data;
    logic                  valid_line_win;
    logic                  ready_win;
    logic [DATA_W*K*K-1:0] win_data;
    logic                  valid_win;
    logic                  ready_out;
    logic [7:0]            out_x;
    logic [7:0]            out_y;

    modport slave (
        input  col_data, valid_line_win, ready_out,
        output ready_win, win_data, valid_win, out_x, out_y
    );

    modport master (
        output col_data, valid_line_win, ready_out,
        input  ready_win, win_data, valid_win, out_x, out_y
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: pulls one KxDATA_W column per handshake from the line
// buffer into a KxK shift register, suppresses the K-1 warm-up columns of
// each output row, and presents every valid window with its (x, y) output
// coordinate. One IMG_W x IMG_H frame is sequenced per start pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame start pulse (honoured only when idle)
//   win_if      : column input / window output handshakes (slave modport)
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last window is taken
module conv_window_ctrl #(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    conv_window_ctrl_if.slave   win_if,
    output logic                busy,
    output logic                frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   col_cnt_q, col_cnt_d;
    logic [RW-1:0]                   row_cnt_q, row_cnt_d;
    // win_q[r][c]: flattening puts element (r,c) at (r*K+c)*DATA_W; c=0 oldest
    logic [K-1:0][K-1:0][DATA_W-1:0] win_q, win_d;
    logic                            valid_win_q, valid_win_d;
    logic [7:0]                      out_x_q, out_x_d;
    logic [7:0]                      out_y_q, out_y_d;
    logic                            frame_done_q, frame_done_d;

    logic ready_win, acc, emit, last_col, last_row;

    always_comb begin
        // Columns only flow while no window is stalled, so win_q is frozen
        // for as long as the engine holds off a presented window.
        ready_win = (state_q == RUN) && (!valid_win_q || win_if.ready_out);
        acc       = win_if.valid_line_win && ready_win;
        emit      = acc && (col_cnt_q >= CW'(K - 1));
        last_col  = (col_cnt_q == CW'(IMG_W - 1));
        last_row  = (row_cnt_q == RW'(IMG_H - K));

        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        win_d        = win_q;
        valid_win_d  = valid_win_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        frame_done_d = 1'b0;

        if (valid_win_q && win_if.ready_out) valid_win_d = 1'b0;

        // A same-cycle emitting column overrides the clear above.
        if (emit) begin
            valid_win_d = 1'b1;
            out_x_d     = 8'(col_cnt_q - CW'(K - 1));
            out_y_d     = 8'(row_cnt_q);
        end

        if (acc) begin
            for (int r = 0; r < K; r++)
                win_d[r] = {win_if.col_data[r*DATA_W +: DATA_W], win_q[r][K-1:1]};
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // frame_done_q is high in the first idle cycle; a start
                // landing on that cycle is dropped.
                if (start && !frame_done_q) begin
                    state_d   = RUN;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            RUN: begin
                if (acc && last_col && last_row) state_d = DONE;
            end
            DONE: begin
                if (!valid_win_q || win_if.ready_out) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            win_q        <= '0;
            valid_win_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            win_q        <= win_d;
            valid_win_q  <= valid_win_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_if.ready_win = ready_win;
    assign win_if.win_data  = win_q;
    assign win_if.valid_win = valid_win_q;
    assign win_if.out_x     = out_x_q;
    assign win_if.out_y     = out_y_q;
    assign busy             = (state_q != IDLE);
    assign frame_done       = frame_done_q;
endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;
    localparam int DATA_W = 8;
    localparam int K      = 5;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int NWIN   = OW * OH;
    localparam int NCOL   = IMG_W * OH;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic frame_done;

    int checks   = 0;
    int failures = 0;

    conv_window_ctrl_if #(.DATA_W(DATA_W), .K(K)) bus ();

    conv_window_ctrl #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .win_if     (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pixel of line-buffer row r at input column col of output row y.
    function automatic logic [7:0] pix(int r, int col, int y);
        return 8'((16 * r + (col % 16) + 3 * y) & 255);
    endfunction

    // Windows a frame has produced after n accepted columns.
    function automatic int emitted(int n);
        int w;
        w = (n % IMG_W) - (K - 1);
        return (n / IMG_W) * OW + ((w > 0) ? w : 0);
    endfunction

    function automatic logic [DATA_W*K*K-1:0] exp_window(int x, int y);
        logic [DATA_W*K*K-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*DATA_W +: DATA_W] = pix(r, x + c, y);
        return v;
    endfunction

    task automatic drive_col(input int n);
        for (int r = 0; r < K; r++)
            bus.col_data[r*DATA_W +: DATA_W] = pix(r, n % IMG_W, n / IMG_W);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.valid_win !== 1'b0 || bus.ready_win !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || bus.out_x !== 8'd0 || bus.out_y !== 8'd0 ||
            bus.win_data !== '0) begin
            failures++;
            $display("FAIL %s: vw=%b rw=%b busy=%b fd=%b x=%0d y=%0d win=%h, required all zero",
                     tag, bus.valid_win, bus.ready_win, busy, frame_done, bus.out_x,
                     bus.out_y, bus.win_data);
        end
    endtask

    // One frame with random source/sink throttling (percent), optional
    // 3-cycle hold at window (2,0), optional stray start pulses.
    task automatic run_frame(input string tag, input int pv, input int pr,
                             input bit bp, input bit poke_start);
        int widx = 0, nacc = 0, cyc = 0, bp_cnt = 0, ex, ey;
        bit done = 0, held = 0, fd_due = 0, fd_next;
        logic [DATA_W*K*K-1:0] prev_win, ew;
        logic [7:0] prev_x = 0, prev_y = 0;
        prev_win = '0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.valid_line_win = 1'b1;
        bus.ready_out = 1'b1;
        drive_col(0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            checks++;
            if (bus.ready_win !== ((nacc < NCOL) && (!bus.valid_win || bus.ready_out))) begin
                failures++;
                $display("FAIL %s ready_win: got %b at nacc=%0d vw=%b ro=%b", tag,
                         bus.ready_win, nacc, bus.valid_win, bus.ready_out);
            end
            checks++;
            if (bus.valid_win !== (emitted(nacc) > widx)) begin
                failures++;
                $display("FAIL %s valid_win: got %b required %b (nacc=%0d widx=%0d)", tag,
                         bus.valid_win, emitted(nacc) > widx, nacc, widx);
            end
            if (bus.valid_win === 1'b1) begin
                ex = widx % OW;
                ey = widx / OW;
                checks++;
                if (bus.out_x !== 8'(ex) || bus.out_y !== 8'(ey)) begin
                    failures++;
                    $display("FAIL %s coord: got (%0d,%0d) required (%0d,%0d)", tag,
                             bus.out_x, bus.out_y, ex, ey);
                end
                ew = exp_window(ex, ey);
                checks++;
                if (bus.win_data !== ew) begin
                    failures++;
                    $display("FAIL %s win_data (%0d,%0d): got %h required %h", tag, ex, ey,
                             bus.win_data, ew);
                end
            end
            if (held) begin
                checks++;
                if (bus.win_data !== prev_win || bus.out_x !== prev_x || bus.out_y !== prev_y) begin
                    failures++;
                    $display("FAIL %s stall hold: got (%0d,%0d) %h required (%0d,%0d) %h", tag,
                             bus.out_x, bus.out_y, bus.win_data, prev_x, prev_y, prev_win);
                end
            end
            checks++;
            if (frame_done !== fd_due || busy !== !fd_due) begin
                failures++;
                $display("FAIL %s frame_done/busy: got %b/%b required %b/%b (widx=%0d)", tag,
                         frame_done, busy, fd_due, !fd_due, widx);
            end
            if (frame_done === 1'b1) done = 1;
            held     = bus.valid_win && !bus.ready_out;
            prev_win = bus.win_data;
            prev_x   = bus.out_x;
            prev_y   = bus.out_y;
            if (bus.valid_line_win && bus.ready_win) nacc++;
            fd_next = bus.valid_win && bus.ready_out && (widx == NWIN - 1);
            if (bus.valid_win && bus.ready_out) widx++;
            fd_due = fd_next;
            if (!done) begin
                @(posedge clk); #1;
                bus.valid_line_win = ($urandom_range(99) < pv);
                bus.ready_out = ($urandom_range(99) < pr);
                if (bp && bus.valid_win && bus.out_x == 8'd2 && bus.out_y == 8'd0 && bp_cnt < 3) begin
                    bus.ready_out = 1'b0;
                    bp_cnt++;
                end
                drive_col(nacc);
                start = poke_start && ($urandom_range(99) < 5);
            end
            cyc++;
        end
        checks++;
        if (!done || widx != NWIN || nacc != NCOL) begin
            failures++;
            $display("FAIL %s frame totals: done=%0d windows=%0d cols=%0d required 1/%0d/%0d",
                     tag, done, widx, nacc, NWIN, NCOL);
        end
        if (bp) begin
            checks++;
            if (bp_cnt != 3) begin
                failures++;
                $display("FAIL %s backpressure cycles: got %0d required 3", tag, bp_cnt);
            end
        end
        // start on the frame_done cycle must be dropped; pulse lasts one cycle
        start = 1'b1;
        bus.valid_line_win = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || bus.ready_win !== 1'b0) begin
            failures++;
            $display("FAIL %s post-frame idle: fd=%b busy=%b rw=%b required 0/0/0", tag,
                     frame_done, busy, bus.ready_win);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        bus.valid_line_win = 1'b0;
        bus.ready_out = 1'b0;
        bus.col_data = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.valid_line_win = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.ready_win !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset idle: rw=%b busy=%b required 0/0", bus.ready_win, busy);
            end
        end
    endtask

    task automatic test_full_frame;
        run_frame("full", 100, 100, 0, 0);
    endtask

    task automatic test_backpressure;
        run_frame("backpressure", 100, 100, 1, 0);
    endtask

    task automatic test_stall_source;
        run_frame("stall_src", 50, 100, 0, 1);
    endtask

    task automatic test_random;
        run_frame("random", 70, 60, 0, 1);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start = 1'b1;
        bus.valid_line_win = 1'b1;
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.ready_win !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid idle: rw=%b busy=%b fd=%b required 0/0/0",
                         bus.ready_win, busy, frame_done);
            end
        end
        run_frame("restart", 100, 100, 0, 0);
    endtask

    task automatic test_back_to_back;
        run_frame("b2b_a", 90, 90, 0, 0);
        run_frame("b2b_b", 100, 100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stall_source();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
